// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display formatter: segment codes,
// the conversion state encoding and the common-anode polarity helper.
package calc_disp_pkg;

   // Conversion sequence: latch -> clear/load -> one bit per clock -> encode.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      ENCODE = 2'd3
   } state_t;

   // Segment order is {dp,g,f,e,d,c,b,a}; all codes are active-high here.
   localparam logic [7:0] SEG_DIG [0:9] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
   };
   localparam logic [7:0] SEG_MINUS = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_R     = 8'h50;

   // Converts an active-high code to the polarity the display wiring needs.
   function automatic logic [7:0] seg_pol(input logic [7:0] code, input logic inv);
      return inv ? ~code : code;
   endfunction

endpackage

// File: rtl/calc_disp_format_seg7.sv
// One display digit: BCD nibble to active-high 7-segment code.
// A set blank flag (leading zero) or a non-decimal nibble gives a dark digit.
module seg7_encode
   import calc_disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [7:0] code
);

   // Table lookup with blanking override.
   always_comb begin
      code = SEG_BLANK;
      if (!blank && (nibble <= 4'd9)) begin
         code = SEG_DIG[nibble];
      end
   end

endmodule

// File: rtl/calc_disp_format.sv
// Calculator result formatter: iterative double-dabble binary-to-BCD
// conversion (one bit per clock) followed by 7-segment encoding with
// leading-zero blanking, minus sign and "Err" indication.
// Handshake: start is sampled only in IDLE; busy is high from the accepting
// edge until the edge that loads seg_data/num, on which done pulses for one
// cycle. seg_data/num then hold until the next conversion completes.
// DIGITS must be at least 3 so that "Err" fits.
module calc_disp_format
   import calc_disp_pkg::*;
#(
   parameter int WIDTH        = 14,
   parameter int DIGITS       = 4,
   parameter int COMMON_ANODE = 1,
   localparam int NUM_W       = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic                  neg,
   input  logic                  err,
   output logic                  busy,
   output logic                  done,
   output logic [8*DIGITS-1:0]   seg_data,
   output logic [NUM_W-1:0]      num
);

   localparam int          CNT_W   = $clog2(WIDTH + 1);
   localparam int          BCD_W   = 4 * DIGITS;
   localparam logic [31:0] MAX_POS = 32'(10 ** DIGITS - 1);
   localparam logic [31:0] MAX_NEG = 32'(10 ** (DIGITS - 1) - 1);
   localparam logic        INV     = (COMMON_ANODE != 0);

   state_t             state, state_nx;
   logic [WIDTH-1:0]   value_q;
   logic               neg_q, err_q;
   logic [WIDTH-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q, bcd_adj;
   logic [CNT_W-1:0]   cnt_q;

   logic [NUM_W-1:0]   sig_n;
   logic [DIGITS-1:0]  blank;
   logic [7:0]         digit_code [DIGITS];
   logic [7:0]         raw [DIGITS];
   logic [8*DIGITS-1:0] seg_nx;
   logic [NUM_W-1:0]   num_nx;
   logic               show_err, show_minus;

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; SHIFT runs until the bit counter reaches zero.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    state_nx = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(1)) state_nx = ENCODE;
         ENCODE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand latch, double-dabble registers and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q  <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         done     <= 1'b0;
         num      <= '0;
         seg_data <= {DIGITS{seg_pol(SEG_BLANK, INV)}};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  value_q <= value;
                  neg_q   <= neg;
                  err_q   <= err;
               end
            end
            LOAD: begin
               bcd_q <= '0;
               bin_q <= value_q;
               cnt_q <= CNT_W'(WIDTH);
            end
            SHIFT: begin
               {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
               cnt_q          <= cnt_q - CNT_W'(1);
            end
            ENCODE: begin
               seg_data <= seg_nx;
               num      <= num_nx;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Significant-digit count; a zero result still shows one digit.
   always_comb begin
      sig_n = NUM_W'(1);
      for (int i = 1; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) sig_n = NUM_W'(i + 1);
      end
   end

   // One encoder per digit; digits above the significant count are dark.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign blank[g] = (NUM_W'(g) >= sig_n);
      seg7_encode u_enc (
         .nibble (bcd_q[4*g +: 4]),
         .blank  (blank[g]),
         .code   (digit_code[g])
      );
   end

   // Special-code mux: error display wins, then minus sign, then plain digits.
   always_comb begin
      show_err   = err_q || (32'(value_q) > MAX_POS) || (neg_q && (32'(value_q) > MAX_NEG));
      show_minus = neg_q && (value_q != '0);
      num_nx     = show_minus ? (sig_n + NUM_W'(1)) : sig_n;
      for (int i = 0; i < DIGITS; i++) begin
         raw[i] = digit_code[i];
         if (show_minus && (NUM_W'(i) == sig_n)) raw[i] = SEG_MINUS;
      end
      if (show_err) begin
         for (int i = 0; i < DIGITS; i++) raw[i] = SEG_BLANK;
         raw[0] = SEG_R;
         raw[1] = SEG_R;
         raw[2] = SEG_E;
         num_nx = NUM_W'(3);
      end
      seg_nx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         seg_nx[8*i +: 8] = seg_pol(raw[i], INV);
      end
   end

endmodule

// File: tb/tb_calc_disp_format.sv
// Bench for calc_disp_format (WIDTH=14, DIGITS=4, active-high segments).
// Drivers push {done cycle, num, seg_data} into exp_q when a conversion is
// requested; the monitor pops and compares on every done pulse.
module tb_calc_disp_format;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [13:0] value;
   logic        neg;
   logic        err;
   logic        busy;
   logic        done;
   logic [31:0] seg_data;
   logic [2:0]  num;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // {done_cycle[15:0], num[2:0], seg_data[31:0]}
   logic [50:0] exp_q[$];

   calc_disp_format #(
      .WIDTH(14), .DIGITS(4), .COMMON_ANODE(0)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .value(value), .neg(neg), .err(err),
      .busy(busy), .done(done), .seg_data(seg_data), .num(num)
   );

   // Clock and edge counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            logic [50:0] e;
            e = exp_q.pop_front();
            check("seg_data", seg_data, e[31:0]);
            check("num", 32'(num), 32'(e[34:32]));
            check("done_cycle", 32'(cyc), 32'(e[50:35]));
            check("busy_after_done", 32'(busy), 32'd0);
         end
      end
   end

   // Single start pulse; the expectation is pushed only when push=1.
   task automatic issue(input logic [13:0] v, input logic n, input logic e,
                        input logic push, input logic [31:0] seg, input logic [2:0] nm);
      @(negedge clk);
      value = v;
      neg   = n;
      err   = e;
      start = 1'b1;
      if (push) exp_q.push_back({16'(cyc + 1 + 16), nm, seg});
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            @(negedge clk);
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle (cycle %0d)", cyc);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; value = '0; neg = 1'b0; err = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_num", 32'(num), 32'd0);
      check("reset_seg", seg_data, 32'h0000_0000);
      rst = 1'b0;

      // Plain four-digit value.
      issue(14'd1234, 1'b0, 1'b0, 1'b1, 32'h065B4F66, 3'd4);
      wait_idle();

      // start held high: 0 then 7, conversions WIDTH+3 = 17 edges apart.
      @(negedge clk);
      value = 14'd0; neg = 1'b0; err = 1'b0; start = 1'b1;
      exp_q.push_back({16'(cyc + 1 + 16), 3'd1, 32'h0000003F});
      @(negedge clk);
      value = 14'd7;
      exp_q.push_back({16'(cyc + 17 + 16), 3'd1, 32'h00000007});
      repeat (17) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Negative values.
      issue(14'd42, 1'b1, 1'b0, 1'b1, 32'h0040665B, 3'd3);
      wait_idle();
      issue(14'd999, 1'b1, 1'b0, 1'b1, 32'h406F6F6F, 3'd4);
      wait_idle();
      // Negative zero shows a bare 0.
      issue(14'd0, 1'b1, 1'b0, 1'b1, 32'h0000003F, 3'd1);
      wait_idle();
      // Largest positive value that fits.
      issue(14'd9999, 1'b0, 1'b0, 1'b1, 32'h6F6F6F6F, 3'd4);
      wait_idle();

      // Error cases.
      issue(14'd10000, 1'b0, 1'b0, 1'b1, 32'h00795050, 3'd3);
      wait_idle();
      issue(14'd1000, 1'b1, 1'b0, 1'b1, 32'h00795050, 3'd3);
      wait_idle();
      issue(14'd5, 1'b0, 1'b1, 1'b1, 32'h00795050, 3'd3);
      wait_idle();

      // Second start during a conversion is ignored.
      issue(14'd56, 1'b0, 1'b0, 1'b1, 32'h00006D7D, 3'd2);
      repeat (3) @(negedge clk);
      value = 14'd99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset at t0+8 discards the conversion.
      issue(14'd1234, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_num", 32'(num), 32'd0);
      check("midreset_seg", seg_data, 32'h0000_0000);
      repeat (25) @(negedge clk);

      // Fresh conversion after reset.
      issue(14'd305, 1'b0, 1'b0, 1'b1, 32'h004F3F6D, 3'd3);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
